data_assemble: RTL and testbench

DATA_ASSEMBLE -- requirements
Module: data_assemble

---
 rtl/data_assemble.sv | 244 ++++++++++++++++++++++++
 tb/tb_data_assemble.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_assemble.sv
// data_assemble: builds one RAM "bag" per frame. A bag is a two-byte header
// chosen by the bag type, followed for DATA bags by DATA_LEN bytes from each
// enabled ADC chip FIFO in ascending chip order. A chip whose FIFO stays empty
// for TIMEOUT consecutive cycles is finished with 0x00 padding and flagged
// in err_pad.
//
// Handshake: the chip FIFOs are first-word-fall-through. fifo_rxen[i] is a
// single-cycle pop strobe raised only while fifo_empty[i] is low, so every
// cycle with fifo_rxen[i]=1 consumes exactly the byte shown on fifo_rxd.
// The RAM side has no back-pressure; every cycle with ram_txen=1 is one write.
module data_assemble #(
  parameter int CHIP_NUM = 8,
  parameter int DATA_LEN = 64,
  parameter int AW       = 12,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fs,
  output logic                  fd,
  input  logic [3:0]            btype,
  input  logic [AW-1:0]         ram_addr_init,
  input  logic [CHIP_NUM-1:0]   chip_mask,
  input  logic [CHIP_NUM-1:0]   fifo_empty,
  input  logic [8*CHIP_NUM-1:0] fifo_rxd,
  output logic [CHIP_NUM-1:0]   fifo_rxen,
  input  logic [31:0]           cache_cmd,
  input  logic [31:0]           cache_stat,
  output logic [AW-1:0]         ram_txa,
  output logic [7:0]            ram_txd,
  output logic                  ram_txen,
  output logic [AW-1:0]         pkt_len,
  output logic                  err_pad,
  output logic [2:0]            state_dbg
);

  localparam int CW = (CHIP_NUM > 1) ? $clog2(CHIP_NUM) : 1;
  localparam int BW = $clog2(DATA_LEN + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(DATA_LEN - 1);
  localparam logic [SW-1:0] LAST_STALL = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_HDR0, ST_HDR1, ST_CSEL, ST_WORK, ST_DONE
  } state_t;

  state_t              state;
  logic [3:0]          bt_q;
  logic [CHIP_NUM-1:0] pending;
  logic [CW-1:0]       cur;
  logic [BW-1:0]       byte_cnt;
  logic [SW-1:0]       stall_cnt;
  logic                pad;
  logic [AW-1:0]       addr_cnt;

  logic                is_data;
  logic [7:0]          hdr0;
  logic [7:0]          hdr1;
  logic [CW-1:0]       nxt_chip;
  logic                any_pending;
  logic [7:0]          cur_byte;
  logic                cur_empty;
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                unused_cache;

  assign state_dbg = state;

  // Header fields that no bag type consumes.
  assign unused_cache = ^{cache_cmd[23:0], cache_stat[31], cache_stat[22:16], cache_stat[3:0]};

  function automatic logic legal_btype(input logic [3:0] b);
    return (b == 4'b1000) || (b == 4'b1001) || (b == 4'b1010) ||
           (b == 4'b1101) || (b == 4'b1110);
  endfunction

  assign is_data = (bt_q == 4'b1101) || (bt_q == 4'b1110);

  // Header bytes for the latched bag type, taken from the live cache words.
  always_comb begin
    hdr0 = 8'h00;
    hdr1 = 8'h00;
    case (bt_q)
      4'b1000: begin
        hdr0 = 8'hD1;
        hdr1 = 8'h23;
      end
      4'b1001: begin
        hdr0 = {4'h1, cache_cmd[31:28]};
        hdr1 = cache_stat[15:8];
      end
      4'b1010: begin
        hdr0 = {4'h9, cache_cmd[31:28]};
        hdr1 = cache_stat[30:23];
      end
      default: begin
        hdr0 = {4'h3, cache_cmd[31:28]};
        hdr1 = {cache_cmd[27:24], cache_stat[7:4]};
      end
    endcase
  end

  // Lowest-index enabled chip that has not been served yet.
  always_comb begin
    nxt_chip    = '0;
    any_pending = |pending;
    for (int i = CHIP_NUM - 1; i >= 0; i--) begin
      if (pending[i]) nxt_chip = CW'(i);
    end
  end

  // Byte and empty flag of the chip currently being read.
  always_comb begin
    cur_byte  = 8'h00;
    cur_empty = 1'b1;
    for (int i = 0; i < CHIP_NUM; i++) begin
      if (CW'(i) == cur) begin
        cur_byte  = fifo_rxd[8*i +: 8];
        cur_empty = fifo_empty[i];
      end
    end
  end

  // Pop strobe: only in WORK, not padding, FIFO non-empty, never during reset.
  always_comb begin
    fifo_rxen = '0;
    for (int i = 0; i < CHIP_NUM; i++) begin
      fifo_rxen[i] = !rst && (state == ST_WORK) && !pad && !cur_empty && (CW'(i) == cur);
    end
  end

  // Which cycles produce a RAM write, and with what byte.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 8'h00;
    case (state)
      ST_HDR0: begin
        wr_en   = 1'b1;
        wr_data = hdr0;
      end
      ST_HDR1: begin
        wr_en   = 1'b1;
        wr_data = hdr1;
      end
      ST_WORK: begin
        wr_en   = pad || !cur_empty;
        wr_data = pad ? 8'h00 : cur_byte;
      end
      default: ;
    endcase
  end

  // Bag sequencer plus registered RAM write port and bag bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bt_q      <= 4'h0;
      pending   <= '0;
      cur       <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      pad       <= 1'b0;
      addr_cnt  <= '0;
      fd        <= 1'b0;
      ram_txa   <= '0;
      ram_txd   <= 8'h00;
      ram_txen  <= 1'b0;
      pkt_len   <= '0;
      err_pad   <= 1'b0;
    end else begin
      ram_txen <= wr_en;
      if (wr_en) begin
        ram_txa  <= addr_cnt;
        ram_txd  <= wr_data;
        addr_cnt <= addr_cnt + AW'(1);
        pkt_len  <= pkt_len + AW'(1);
      end

      case (state)
        ST_IDLE: state <= ST_WAIT;

        ST_WAIT: begin
          if (fs && legal_btype(btype)) begin
            state    <= ST_HDR0;
            bt_q     <= btype;
            pending  <= chip_mask;
            addr_cnt <= ram_addr_init;
            pkt_len  <= '0;
            err_pad  <= 1'b0;
          end
        end

        ST_HDR0: state <= ST_HDR1;

        ST_HDR1: begin
          if (is_data) begin
            state <= ST_CSEL;
          end else begin
            state <= ST_DONE;
            fd    <= 1'b1;
          end
        end

        ST_CSEL: begin
          if (any_pending) begin
            state             <= ST_WORK;
            cur               <= nxt_chip;
            pending[nxt_chip] <= 1'b0;
            byte_cnt          <= '0;
            stall_cnt         <= '0;
            pad               <= 1'b0;
          end else begin
            state <= ST_DONE;
            fd    <= 1'b1;
          end
        end

        ST_WORK: begin
          if (wr_en) begin
            stall_cnt <= '0;
            byte_cnt  <= byte_cnt + BW'(1);
            if (byte_cnt == LAST_BYTE) state <= ST_CSEL;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
            if (stall_cnt == LAST_STALL) begin
              pad     <= 1'b1;
              err_pad <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (!fs) begin
            state <= ST_WAIT;
            fd    <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_assemble.sv
// Bench for data_assemble: FWFT FIFO model per chip, bag-level reference
// model that fills an expected (address, data) queue, and a monitor that
// pops and compares every RAM write.
`timescale 1ns/1ps
module tb_data_assemble;

  localparam int CN = 8;
  localparam int DL = 64;
  localparam int AW = 12;
  localparam int TO = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            fs = 1'b0;
  logic            fd;
  logic [3:0]      btype = 4'h0;
  logic [AW-1:0]   ram_addr_init = '0;
  logic [CN-1:0]   chip_mask = '0;
  logic [CN-1:0]   fifo_empty = '1;
  logic [8*CN-1:0] fifo_rxd = '0;
  logic [CN-1:0]   fifo_rxen;
  logic [31:0]     cache_cmd = '0;
  logic [31:0]     cache_stat = '0;
  logic [AW-1:0]   ram_txa;
  logic [7:0]      ram_txd;
  logic            ram_txen;
  logic [AW-1:0]   pkt_len;
  logic            err_pad;
  logic [2:0]      state_dbg;

  data_assemble #(.CHIP_NUM(CN), .DATA_LEN(DL), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .btype(btype),
    .ram_addr_init(ram_addr_init), .chip_mask(chip_mask),
    .fifo_empty(fifo_empty), .fifo_rxd(fifo_rxd), .fifo_rxen(fifo_rxen),
    .cache_cmd(cache_cmd), .cache_stat(cache_stat),
    .ram_txa(ram_txa), .ram_txd(ram_txd), .ram_txen(ram_txen),
    .pkt_len(pkt_len), .err_pad(err_pad), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+7:0] exp_q[$];

  logic [7:0] fq [CN][$];
  int pop_cnt[CN];
  int pops_seen[CN];
  int gap_chip = -1;
  int gap_after = 0;
  int gap_len = 0;
  int force_cnt = 0;

  int cyc = 0;
  int first_wr = -1;
  int last_wr = -1;
  int wr_cnt = 0;

  int e_len;
  int e_span;
  int e_pad;
  int e_pops[CN];

  logic [3:0] legal_bt[5] = '{4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model (FWFT) ----------------
  task automatic drive_fifos();
    for (int i = 0; i < CN; i++) begin
      fifo_empty[i]      = (fq[i].size() == 0) || (i == gap_chip && force_cnt > 0);
      fifo_rxd[8*i +: 8] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  endtask

  initial begin
    logic [CN-1:0] rx;
    forever begin
      @(negedge clk);
      rx = fifo_rxen;
      @(posedge clk);
      #1;
      for (int i = 0; i < CN; i++) begin
        if (rx[i] && fq[i].size() > 0) begin
          void'(fq[i].pop_front());
          pop_cnt[i]++;
          if (i == gap_chip && pop_cnt[i] == gap_after) force_cnt = gap_len;
        end else if (i == gap_chip && force_cnt > 0) begin
          force_cnt--;
        end
      end
      drive_fifos();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [AW+7:0] e;
    cyc++;
    if (!rst) begin
      if (fifo_rxen != '0) begin
        chk("rxen_onehot", 32'($onehot(fifo_rxen)), 32'd1);
        for (int i = 0; i < CN; i++) if (fifo_rxen[i]) pops_seen[i]++;
      end
      if (ram_txen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", ram_txa, ram_txd);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr_data", 32'({ram_txa, ram_txd}), 32'(e));
        end
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] hdr_bytes(input logic [3:0] bt, input logic [31:0] cmd,
                                            input logic [31:0] st);
    case (bt)
      4'b1000: return {8'hD1, 8'h23};
      4'b1001: return {4'h1, cmd[31:28], st[15:8]};
      4'b1010: return {4'h9, cmd[31:28], st[30:23]};
      default: return {4'h3, cmd[31:28], cmd[27:24], st[7:4]};
    endcase
  endfunction

  // Load FIFOs and compute the expected bag from the rules.
  task automatic prep_bag(input logic [3:0] bt, input logic [CN-1:0] mask, input logic [AW-1:0] addr,
                          input int short_chip, input int short_len,
                          input int gchip, input int gafter, input int glen);
    logic [15:0]   h;
    logic [AW-1:0] a;
    bit            is_data;
    int            avail[CN];
    @(negedge clk);
    cache_cmd     = $urandom();
    cache_stat    = $urandom();
    btype         = bt;
    chip_mask     = mask;
    ram_addr_init = addr;
    gap_chip      = gchip;
    gap_after     = gafter;
    gap_len       = glen;
    force_cnt     = 0;
    for (int i = 0; i < CN; i++) begin
      fq[i].delete();
      pop_cnt[i]   = 0;
      pops_seen[i] = 0;
      avail[i]     = (i == short_chip) ? short_len : DL;
      for (int k = 0; k < avail[i]; k++) fq[i].push_back(8'($urandom()));
    end
    is_data = (bt == 4'b1101) || (bt == 4'b1110);
    h = hdr_bytes(bt, cache_cmd, cache_stat);
    a = addr;
    exp_q.push_back({a, h[15:8]});
    a = a + 1'b1;
    exp_q.push_back({a, h[7:0]});
    a = a + 1'b1;
    e_len  = 2;
    e_span = 2;
    e_pad  = 0;
    for (int i = 0; i < CN; i++) begin
      e_pops[i] = 0;
      if (is_data && mask[i]) begin
        e_pops[i] = (avail[i] < DL) ? avail[i] : DL;
        e_span += 1 + DL;
        for (int k = 0; k < DL; k++) begin
          exp_q.push_back({a, (k < avail[i]) ? fq[i][k] : 8'h00});
          a = a + 1'b1;
          e_len++;
        end
        if (avail[i] < DL) begin
          e_pad = 1;
          e_span += TO;
        end
        if (i == gchip && gafter < avail[i]) e_span += glen;
      end
    end
    first_wr = -1;
    last_wr  = -1;
  endtask

  // ---------------- driver ----------------
  task automatic run_bag(input string tag, input logic [3:0] bt, input logic [CN-1:0] mask,
                         input logic [AW-1:0] addr, input int short_chip, input int short_len,
                         input int gchip, input int gafter, input int glen, input bit wiggle);
    int n;
    prep_bag(bt, mask, addr, short_chip, short_len, gchip, gafter, glen);
    @(posedge clk);
    #2;
    fs = 1'b1;
    if (wiggle) begin
      n = 0;
      while (first_wr < 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      #1;
      btype     = 4'($urandom());
      chip_mask = CN'($urandom());
    end
    n = 0;
    while (!fd && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, " fd_rise"}, 32'(fd), 32'd1);
    chk({tag, " pkt_len"}, 32'(pkt_len), 32'(e_len));
    chk({tag, " err_pad"}, 32'(err_pad), 32'(e_pad));
    chk({tag, " writes_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " write_span"}, 32'(last_wr - first_wr + 1), 32'(e_span));
    for (int i = 0; i < CN; i++) chk({tag, " pops"}, 32'(pops_seen[i]), 32'(e_pops[i]));
    repeat (3) @(negedge clk);
    chk({tag, " fd_hold"}, 32'(fd), 32'd1);
    chk({tag, " pkt_len_hold"}, 32'(pkt_len), 32'(e_len));
    fs = 1'b0;
    @(negedge clk);
    chk({tag, " fd_fall"}, 32'(fd), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start;
    int n;
    int sc;
    int gc;
    drive_fifos();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset fd", 32'(fd), 32'd0);
    chk("reset fifo_rxen", 32'(fifo_rxen), 32'd0);
    chk("reset ram_txen", 32'(ram_txen), 32'd0);
    chk("reset ram_txa", 32'(ram_txa), 32'd0);
    chk("reset ram_txd", 32'(ram_txd), 32'd0);
    chk("reset pkt_len", 32'(pkt_len), 32'd0);
    chk("reset err_pad", 32'(err_pad), 32'd0);
    rst = 1'b0;

    run_bag("dlink",   4'b1000, 8'hFF, 12'h100, -1, 0, -1, 0, 0, 1'b0);
    run_bag("data_ff", 4'b1101, 8'hFF, 12'h100, -1, 0, -1, 0, 0, 1'b0);
    run_bag("data_05", 4'b1110, 8'h05, 12'h040, -1, 0, -1, 0, 0, 1'b0);
    run_bag("gap",     4'b1101, 8'h0F, 12'h200, -1, 0, 1, 20, 10, 1'b0);
    run_bag("timeout", 4'b1101, 8'hFF, 12'h300, 3, 17, -1, 0, 0, 1'b0);
    run_bag("mask0",   4'b1101, 8'h00, 12'h7A0, -1, 0, -1, 0, 0, 1'b0);
    run_bag("dtype",   4'b1001, 8'h33, 12'h010, -1, 0, -1, 0, 0, 1'b1);
    run_bag("dtemp",   4'b1010, 8'h81, 12'hABC, -1, 0, -1, 0, 0, 1'b1);
    run_bag("wrap",    4'b1110, 8'h82, 12'hFF8, -1, 0, -1, 0, 0, 1'b1);

    // Illegal bag type is ignored even with fs high.
    @(negedge clk);
    btype = 4'b0011;
    fs    = 1'b1;
    repeat (30) @(negedge clk);
    chk("illegal fd", 32'(fd), 32'd0);
    chk("illegal pkt_len", 32'(pkt_len), 32'(e_len));
    fs = 1'b0;
    @(negedge clk);

    // Reset in the middle of WORK, then a clean bag.
    prep_bag(4'b1101, 8'hFF, 12'h100, -1, 0, -1, 0, 0);
    @(posedge clk);
    #2;
    fs    = 1'b1;
    start = wr_cnt;
    n     = 0;
    while (wr_cnt < start + 40 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst reached_work", 32'(wr_cnt >= start + 40), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fs  = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst rxen_gated", 32'(fifo_rxen), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst fd", 32'(fd), 32'd0);
    chk("midrst ram_txen", 32'(ram_txen), 32'd0);
    chk("midrst ram_txa", 32'(ram_txa), 32'd0);
    chk("midrst ram_txd", 32'(ram_txd), 32'd0);
    chk("midrst pkt_len", 32'(pkt_len), 32'd0);
    chk("midrst err_pad", 32'(err_pad), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    run_bag("after_rst", 4'b1101, 8'hFF, 12'h100, -1, 0, -1, 0, 0, 1'b0);

    // Randomized bags.
    for (int r = 0; r < 6; r++) begin
      sc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CN - 1)) : -1;
      gc = $urandom_range(0, CN - 1);
      if (gc == sc) gc = -1;
      run_bag("rand", legal_bt[$urandom_range(0, 4)], CN'($urandom()), AW'($urandom()),
              sc, $urandom_range(0, DL - 1), gc, $urandom_range(1, DL - 1),
              $urandom_range(1, 40), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, required finish before 900000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
